sobel_frame_writer: RTL and testbench
=====================================

SOBEL_FRAME_WRITER -- requirements
Module: sobel_frame_writer

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 720, pixels per row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 540, rows per frame.
REQ-003 SHALL have parameter DWIDTH, default 8, pixel width in bits.
REQ-004 SHALL have parameter AWIDTH, default 19, memory address width; AWIDTH >= clog2(IMG_WIDTH*IMG_HEIGHT).
REQ-005 SHALL have one clock, clock; reset is synchronous and active-high, named reset.
REQ-006 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  single-cycle request to capture one frame.
REQ-009 SHALL have port fifo_in_rd_en  output  1  pop strobe to upstream FIFO.
REQ-010 SHALL have port fifo_in_dout  input  DWIDTH  upstream FIFO head data.
REQ-011 SHALL have port fifo_in_empty  input  1  upstream FIFO empty flag.
REQ-012 SHALL have port mem_wr_en  output  1  frame memory write strobe.
REQ-013 SHALL have port mem_addr  output  AWIDTH  frame memory write address.
REQ-014 SHALL have port mem_din  output  DWIDTH  frame memory write data.
REQ-015 SHALL have port busy  output  1  high while a frame is being captured.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at frame end.
REQ-017 SHALL have port frame_count  output  16  completed frames, mod 2^16.
REQ-018 SHALL have port checksum  output  32  sum of all pixels of the last completed frame, mod 2^32.

Function
REQ-019 SHALL treat the upstream FIFO as show-ahead: fifo_in_dout is valid whenever fifo_in_empty=0; fifo_in_rd_en=1 consumes that word at the clock edge.
REQ-020 SHALL implement states IDLE, RUN, DONE.
REQ-021 IDLE: start=1 -> RUN, pixel counter and running sum cleared to 0; start=0 -> stay.
REQ-022 RUN: fifo_in_rd_en SHALL be combinational, equal to !fifo_in_empty; never asserted in IDLE or DONE.
REQ-023 RUN: each pop SHALL register mem_wr_en=1, mem_din=popped word, mem_addr=pixel counter, visible the cycle after the pop (latency 1).
REQ-024 Cycles without a pop SHALL register mem_wr_en=0; mem_addr/mem_din hold their last values.
REQ-025 Each pop SHALL increment the pixel counter by 1 and add the zero-extended word to the running sum.
REQ-026 The pop with pixel counter = IMG_WIDTH*IMG_HEIGHT-1 SHALL move RUN -> DONE.
REQ-027 DONE (exactly one cycle): frame_done=1, coinciding with the last mem_wr_en; checksum <= final running sum; frame_count += 1 (wrap 0xFFFF -> 0); then -> IDLE.
REQ-028 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-029 start SHALL be ignored in RUN and DONE; start in the IDLE cycle right after DONE SHALL begin a new frame.
REQ-030 fifo_in_empty toggling mid-frame SHALL only stall; no pixel lost, duplicated or reordered; addresses strictly 0,1,2,... with no gaps.
REQ-031 Words present in the FIFO while IDLE SHALL remain unconsumed.
REQ-032 checksum SHALL update only at frame_done; it holds during the next frame.

Reset
REQ-033 reset=1 SHALL force IDLE, fifo_in_rd_en=0, mem_wr_en=0, mem_addr=0, mem_din=0, busy=0, frame_done=0, frame_count=0, checksum=0, pixel counter and running sum 0.
REQ-034 reset SHALL take priority over start and over any pop in the same cycle; a frame aborted by reset SHALL NOT count or update checksum.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2 unless noted)
REQ-035 Reset, start, FIFO always non-empty with data 1..8 -> mem writes addr 0..7 data 1..8 on 8 consecutive cycles, frame_done with addr 7, checksum=36, frame_count=1.
REQ-036 Same frame, fifo_in_empty high every other cycle -> identical addr/data sequence, no rd_en while empty, frame_done one cycle after 8th pop.
REQ-037 start pulsed again mid-RUN and FIFO pre-loaded while IDLE -> no extra frame, no pops before start, frame_count increments once.
REQ-038 reset asserted after 5th pop, then a full frame of 0xFF -> addresses restart at 0, checksum=0x7F8, frame_count=1.
REQ-039 Two back-to-back frames (start in the cycle after frame_done) with data all 0x02 then all 0x03 -> checksum 16 then 24, frame_count 2.
REQ-040 Force frame_count to 0xFFFF (65535 frames, IMG_WIDTH=IMG_HEIGHT=1) then one more frame -> frame_count=0.

Source files
------------

// File: rtl/sobel_frame_writer_if.sv
// Upstream show-ahead FIFO pop port and frame-memory write port of the frame writer.
interface sobel_frame_writer_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 19
);
  logic              fifo_in_rd_en;
  logic [DWIDTH-1:0] fifo_in_dout;
  logic              fifo_in_empty;
  logic              mem_wr_en;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;

  modport master (
    output fifo_in_rd_en, mem_wr_en, mem_addr, mem_din,
    input  fifo_in_dout, fifo_in_empty
  );

  modport slave (
    input  fifo_in_rd_en, mem_wr_en, mem_addr, mem_din,
    output fifo_in_dout, fifo_in_empty
  );
endinterface

// File: rtl/sobel_frame_writer.sv
// Drains one frame of pixels from a show-ahead FIFO into frame memory on request,
// tracking completed frames and a per-frame pixel checksum.
module sobel_frame_writer #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8,
  parameter int AWIDTH     = 19
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  sobel_frame_writer_if.master bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic [31:0]          checksum
);
  localparam int unsigned NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [AWIDTH-1:0] LAST_PIX = AWIDTH'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] pix_q, pix_d;
  logic [31:0]       sum_q, sum_d;
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] din_q, din_d;
  logic [31:0]       cks_q, cks_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              pop;

  // Reset gates the combinational outputs so they read inactive in the reset cycle itself.
  assign pop               = (state_q == RUN) && !bus.fifo_in_empty && !reset;
  assign bus.fifo_in_rd_en = pop;
  assign bus.mem_wr_en     = wr_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_din       = din_q;
  assign busy              = (state_q != IDLE) && !reset;
  assign frame_done        = (state_q == DONE) && !reset;
  assign frame_count       = frame_count_q;
  assign checksum          = cks_q;

  always_comb begin
    state_d       = state_q;
    pix_d         = pix_q;
    sum_d         = sum_q;
    wr_d          = 1'b0;
    addr_d        = addr_q;
    din_d         = din_q;
    cks_d         = cks_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pix_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        if (pop) begin
          wr_d   = 1'b1;
          addr_d = pix_q;
          din_d  = bus.fifo_in_dout;
          pix_d  = pix_q + AWIDTH'(1);
          sum_d  = sum_q + 32'(bus.fifo_in_dout);
          if (pix_q == LAST_PIX) state_d = DONE;
        end
      end
      DONE: begin
        // Last pixel's write is on the bus this cycle; commit frame results.
        cks_d         = sum_q;
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      pix_q         <= '0;
      sum_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      cks_q         <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      sum_q         <= sum_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      cks_q         <= cks_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_sobel_frame_writer.sv
// Directed bench for sobel_frame_writer: FIFO model feeds pops, a scoreboard checks memory writes.
module tb_sobel_frame_writer;
  localparam int W = 4, H = 2, DW = 8, AW = 19, NPIX = W * H;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1, start = 1'b0;
  logic busy, frame_done;
  logic [15:0] frame_count;
  logic [31:0] checksum;

  logic reset1 = 1'b1, start1 = 1'b0;
  logic busy1, frame_done1;
  logic [15:0] frame_count1;
  logic [31:0] checksum1;

  sobel_frame_writer_if #(.DWIDTH(DW), .AWIDTH(AW)) bus();
  sobel_frame_writer_if #(.DWIDTH(DW), .AWIDTH(4))  bus1();

  sobel_frame_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count), .checksum(checksum)
  );

  sobel_frame_writer #(.IMG_WIDTH(1), .IMG_HEIGHT(1), .DWIDTH(DW), .AWIDTH(4)) dut1 (
    .clock(clock), .reset(reset1), .start(start1), .bus(bus1),
    .busy(busy1), .frame_done(frame_done1), .frame_count(frame_count1), .checksum(checksum1)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  logic [7:0] fifo[$];
  exp_t sb[$];
  int exp_addr = 0, cyc_n = 0, last_pop_cyc = 0, done_cyc = 0, pops = 0;
  bit done_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample just after, then advance past the next edge.
  task automatic cyc(input logic st, input logic stall);
    exp_t e;
    start = st;
    bus.fifo_in_empty = stall || (fifo.size() == 0);
    bus.fifo_in_dout  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    if (bus.mem_wr_en) begin
      if (sb.size() == 0) chk("unexpected_write", {31'd0, bus.mem_wr_en}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_din", bus.mem_din, e.data);
      end
    end
    if (frame_done) begin
      done_seen = 1;
      done_cyc  = cyc_n;
      chk("done_with_wr", {31'd0, bus.mem_wr_en}, 32'd1);
      chk("done_addr", bus.mem_addr, NPIX - 1);
      chk("done_latency", cyc_n - last_pop_cyc, 1);
    end
    if (bus.fifo_in_rd_en) begin
      chk("rd_en_while_empty", {31'd0, bus.fifo_in_empty}, 32'd0);
      chk("rd_en_when_busy", {31'd0, busy}, 32'd1);
      if (fifo.size() != 0) begin
        e.addr = exp_addr;
        e.data = 32'(fifo[0]);
        sb.push_back(e);
        exp_addr++;
        void'(fifo.pop_front());
        pops++;
        last_pop_cyc = cyc_n;
      end
    end
    @(posedge clock);
    #1;
    cyc_n++;
  endtask

  task automatic run_frame(input logic [7:0] first, input logic [7:0] step, input bit stall_odd,
                           input int mid_start, input int exp_len, input logic [31:0] exp_cks,
                           input logic [15:0] exp_count);
    logic [31:0] prev_cks;
    int i, c0;
    if (fifo.size() == 0)
      for (int k = 0; k < NPIX; k++) fifo.push_back(first + 8'(k) * step);
    exp_addr  = 0;
    done_seen = 0;
    prev_cks  = checksum;
    c0        = cyc_n;
    cyc(1'b1, 1'b0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    i = 0;
    while (!done_seen && i < 200) begin
      chk("checksum_hold", checksum, prev_cks);
      cyc(i == mid_start, stall_odd && (i % 2 == 1));
      i++;
    end
    if (!done_seen) chk("frame_done_timeout", {31'd0, done_seen}, 32'd1);
    else chk("frame_length", done_cyc - c0, exp_len);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("checksum", checksum, exp_cks);
    chk("frame_count", {16'd0, frame_count}, {16'd0, exp_count});
    chk("sb_drained", sb.size(), 0);
    chk("fifo_drained", fifo.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    bus.fifo_in_empty  = 1'b0;
    bus.fifo_in_dout   = 8'hAA;
    bus1.fifo_in_empty = 1'b1;
    bus1.fifo_in_dout  = 8'h00;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_en", {31'd0, bus.fifo_in_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_din", bus.mem_din, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    reset = 1'b0;
    cyc(1'b0, 1'b1);
    chk("start_in_reset_ignored", {31'd0, busy}, 32'd0);

    // Data 1..8, FIFO never empty
    run_frame(8'd1, 8'd1, 1'b0, -1, 9, 32'd36, 16'd1);
    // Same data, FIFO empty every other cycle
    run_frame(8'd1, 8'd1, 1'b1, -1, 16, 32'd36, 16'd2);

    // Pre-loaded FIFO stays untouched while idle; start re-pulsed mid-frame is ignored
    for (int k = 0; k < NPIX; k++) fifo.push_back(8'(10 + k));
    pops_before = pops;
    repeat (4) cyc(1'b0, 1'b0);
    chk("idle_no_pop", pops, pops_before);
    chk("idle_fifo_kept", fifo.size(), NPIX);
    run_frame(8'd10, 8'd1, 1'b0, 3, 9, 32'd108, 16'd3);
    for (int k = 0; k < 3; k++) fifo.push_back(8'hC0);
    pops_before = pops;
    repeat (5) cyc(1'b0, 1'b0);
    chk("no_extra_frame_pops", pops, pops_before);
    chk("no_extra_frame_count", {16'd0, frame_count}, 32'd3);
    fifo.delete();

    // Abort by reset after the fifth pop
    for (int k = 0; k < NPIX; k++) fifo.push_back(8'(8'h40 + k));
    exp_addr = 0;
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    reset = 1'b1;
    start = 1'b1;
    bus.fifo_in_empty = 1'b0;
    #1;
    chk("reset_rd_en", {31'd0, bus.fifo_in_rd_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    chk("abort_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
    chk("abort_addr", bus.mem_addr, 32'd0);
    chk("abort_din", bus.mem_din, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", {16'd0, frame_count}, 32'd0);
    chk("abort_checksum", checksum, 32'd0);
    chk("abort_sb", sb.size(), 0);
    fifo.delete();
    run_frame(8'hFF, 8'd0, 1'b0, -1, 9, 32'h7F8, 16'd1);

    // Back-to-back frames after a fresh reset
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    reset = 1'b0;
    run_frame(8'h02, 8'd0, 1'b0, -1, 9, 32'd16, 16'd1);
    run_frame(8'h03, 8'd0, 1'b0, -1, 9, 32'd24, 16'd2);

    // Frame counter wrap on a 1x1 instance
    @(negedge clock);
    reset1 = 1'b0;
    force dut1.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release dut1.frame_count_q;
    @(negedge clock);
    chk("wrap_preset", {16'd0, frame_count1}, 32'h0000FFFF);
    start1 = 1'b1;
    bus1.fifo_in_empty = 1'b0;
    bus1.fifo_in_dout  = 8'h5A;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10 && !done_seen; i++) begin
      #1;
      if (frame_done1) begin
        done_seen = 1;
        chk("wrap_wr_en", {31'd0, bus1.mem_wr_en}, 32'd1);
        chk("wrap_din", bus1.mem_din, 32'h5A);
        chk("wrap_addr", bus1.mem_addr, 32'd0);
      end
      @(posedge clock);
      #1;
    end
    if (!done_seen) chk("wrap_done_timeout", {31'd0, done_seen}, 32'd1);
    chk("wrap_count", {16'd0, frame_count1}, 32'd0);
    chk("wrap_checksum", checksum1, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
